// File: rtl/ktn_cpu.sv
// ktn_cpu: parametrised multi-cycle accumulator CPU with a req/ack data-memory port.
module ktn_cpu #(
  parameter int DATA_W = 8,
  parameter int PC_W = 8,
  parameter int DADDR_W = 8,
  localparam int INSTR_W = DATA_W + 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instruction,
  output logic [PC_W-1:0]    code_address,
  output logic               mem_req,
  output logic               mem_we,
  output logic [DADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  input  logic               mem_ack,
  output logic               kd_reset,
  output logic               r_zero,
  output logic               carry
);
  typedef enum logic [1:0] {FETCH, EXEC, MEM} state_t;
  state_t state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, r_q, r_d;
  logic c_q, c_d;
  logic [3:0] op;
  logic [DATA_W-1:0] k;
  logic [DATA_W:0] alu_x;
  assign op = ir_q[INSTR_W-1 -: 4];
  assign k = ir_q[DATA_W-1:0];
  assign code_address = pc_q;
  assign mem_req = state_q == MEM;
  assign mem_we = op == 4'd5;
  assign mem_addr = ir_q[DADDR_W-1:0];
  assign mem_wdata = r_q;
  assign kd_reset = state_q == EXEC && op == 4'd9;
  assign r_zero = r_q == '0;
  assign carry = c_q;
  // alu_x packs {carry/borrow, result}
  always_comb begin
    alu_x = '0;
    case (k[3:0])
      4'd0: alu_x = {1'b0, a_q} + {1'b0, b_q};
      4'd1: alu_x = {1'b0, a_q} - {1'b0, b_q};
      4'd2: alu_x = {1'b0, a_q & b_q};
      4'd3: alu_x = {1'b0, a_q | b_q};
      4'd4: alu_x = {1'b0, a_q ^ b_q};
      4'd5: alu_x = {1'b0, ~a_q};
      4'd6: alu_x = {a_q, 1'b0};
      4'd7: alu_x = {a_q[0], 1'b0, a_q[DATA_W-1:1]};
      4'd8: alu_x = {1'b0, a_q} + {1'b0, b_q} + {{DATA_W{1'b0}}, c_q};
      4'd9: alu_x = {1'b0, b_q};
      default: alu_x = '0;
    endcase
  end
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    ir_d = ir_q;
    a_d = a_q;
    b_d = b_q;
    r_d = r_q;
    c_d = c_q;
    case (state_q)
      FETCH: begin
        ir_d = instruction;
        pc_d = pc_q + PC_W'(1);
        state_d = EXEC;
      end
      EXEC: begin
        state_d = FETCH;
        case (op)
          4'd1, 4'd2, 4'd5: state_d = MEM;
          4'd3: b_d = k;
          4'd4: begin
            r_d = alu_x[DATA_W-1:0];
            c_d = alu_x[DATA_W];
          end
          4'd6: pc_d = r_zero ? pc_q - PC_W'(k) : pc_q;
          4'd7: pc_d = r_zero ? pc_q + PC_W'(k) : pc_q;
          4'd8: pc_d = PC_W'(k);
          default: ;
        endcase
      end
      MEM: begin
        state_d = mem_ack ? FETCH : MEM;
        a_d = (mem_ack && op == 4'd1) ? mem_rdata : a_q;
        b_d = (mem_ack && op == 4'd2) ? mem_rdata : b_q;
      end
      default: state_d = FETCH;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH;
      pc_q <= '0;
      ir_q <= '0;
      a_q <= '0;
      b_q <= '0;
      r_q <= '0;
      c_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ir_q <= ir_d;
      a_q <= a_d;
      b_q <= b_d;
      r_q <= r_d;
      c_q <= c_d;
    end
  end
endmodule

// File: tb/tb_ktn_cpu.sv
// tb_ktn_cpu: directed and random instruction streams checked against an ISA-level model.
module tb_ktn_cpu;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, mem_req, mem_we, mem_ack, kd_reset, r_zero, carry;
  logic [11:0] instruction;
  logic [7:0] code_address, mem_addr, mem_wdata, mem_rdata;
  logic [19:0] instr16;
  logic [9:0] code_address16;
  logic mem_req16, mem_we16, kd_reset16, r_zero16, carry16;
  logic [7:0] mem_addr16;
  logic [15:0] mem_wdata16;
  int n_chk = 0, n_fail = 0;
  int m_pc, m_a, m_b, m_r, m_c;

  ktn_cpu dut (
    .clk(clk), .rst(rst), .instruction(instruction), .code_address(code_address),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .kd_reset(kd_reset), .r_zero(r_zero), .carry(carry)
  );

  // wide build runs LDBI 1; SUB from code 0 and 1, NOPs elsewhere
  assign instr16 = code_address16 == 10'd0 ? {4'd3, 16'd1} : code_address16 == 10'd1 ? {4'd4, 16'd1} : 20'd0;
  ktn_cpu #(.DATA_W(16), .PC_W(10), .DADDR_W(8)) dut16 (
    .clk(clk), .rst(rst), .instruction(instr16), .code_address(code_address16),
    .mem_req(mem_req16), .mem_we(mem_we16), .mem_addr(mem_addr16), .mem_wdata(mem_wdata16),
    .mem_rdata(16'd0), .mem_ack(1'b0), .kd_reset(kd_reset16), .r_zero(r_zero16), .carry(carry16)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_alu(input int f);
    int s;
    case (f)
      0: begin s = m_a + m_b; m_r = s % 256; m_c = s > 255; end
      1: begin m_c = m_a < m_b; m_r = (m_a - m_b + 256) % 256; end
      2: begin m_r = m_a & m_b; m_c = 0; end
      3: begin m_r = m_a | m_b; m_c = 0; end
      4: begin m_r = m_a ^ m_b; m_c = 0; end
      5: begin m_r = 255 - m_a; m_c = 0; end
      6: begin m_c = m_a >= 128; m_r = (m_a * 2) % 256; end
      7: begin m_c = m_a % 2; m_r = m_a / 2; end
      8: begin s = m_a + m_b + m_c; m_r = s % 256; m_c = s > 255; end
      9: begin m_r = m_b; m_c = 0; end
      default: begin m_r = 0; m_c = 0; end
    endcase
  endtask

  // entered and left at the falling edge of a FETCH cycle
  task automatic run(input int op, input int k, input int waits, input logic spur, input logic [7:0] rd);
    check("pc", code_address, m_pc);
    check("r", mem_wdata, m_r);
    check("carry", carry, m_c);
    check("r_zero", r_zero, m_r == 0);
    check("req_fetch", mem_req, 0);
    check("kdr_fetch", kd_reset, 0);
    instruction = {op[3:0], k[7:0]};
    @(negedge clk);
    m_pc = (m_pc + 1) % 256;
    check("kdr_exec", kd_reset, op == 9);
    check("req_exec", mem_req, 0);
    mem_ack = spur;
    @(negedge clk);
    mem_ack = 1'b0;
    if (op == 1 || op == 2 || op == 5) begin
      for (int i = 0; i <= waits; i++) begin
        check("req_mem", mem_req, 1);
        check("we_mem", mem_we, op == 5);
        check("addr_mem", mem_addr, k);
        check("wdata_mem", mem_wdata, m_r);
        mem_rdata = rd;
        mem_ack = i == waits;
        @(negedge clk);
      end
      mem_ack = 1'b0;
      if (op == 1) m_a = rd;
      if (op == 2) m_b = rd;
    end else begin
      case (op)
        3: m_b = k;
        4: model_alu(k % 16);
        6: if (m_r == 0) m_pc = (m_pc - k + 256) % 256;
        7: if (m_r == 0) m_pc = (m_pc + k) % 256;
        8: m_pc = k;
        default: ;
      endcase
    end
  endtask

  initial begin
    rst = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    instruction = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    instruction = {4'd1, 8'h33};
    repeat (2) @(negedge clk);
    check("req_before_rst", mem_req, 1);
    #2 rst = 1'b0;
    #1 check("req_async_rst", mem_req, 0);
    @(negedge clk);
    rst = 1'b1;
    check("rst_pc", code_address, 0);
    check("rst_rzero", r_zero, 1);
    check("rst_carry", carry, 0);
    {m_pc, m_a, m_b, m_r, m_c} = '0;
    run(3, 8'h05, 0, 0, 0);
    run(1, 8'h10, 3, 0, 8'h0C);
    run(4, 0, 0, 0, 0);
    check("add_r", mem_wdata, 8'h11);
    check("add_c", carry, 0);
    run(1, 8'h40, 0, 0, 8'hFF);
    run(3, 1, 0, 0, 0);
    run(4, 0, 0, 0, 0);
    check("addwrap_r", mem_wdata, 8'h00);
    check("addwrap_rz", r_zero, 1);
    check("addwrap_c", carry, 1);
    run(4, 8, 0, 0, 0);
    check("adc_r", mem_wdata, 8'h01);
    check("adc_c", carry, 1);
    run(4, 10, 0, 0, 0);
    run(8, 0, 0, 0, 0);
    run(6, 3, 0, 0, 0);
    check("ju_wrap_pc", code_address, 8'hFE);
    run(4, 9, 0, 0, 0);
    run(7, 4, 0, 0, 0);
    check("jd_not_taken_pc", code_address, 8'h00);
    run(3, 8'hA5, 0, 0, 0);
    run(4, 9, 0, 0, 0);
    run(5, 8'h20, 2, 1, 0);
    run(9, 0, 0, 0, 0);
    for (int n = 0; n < 400; n++)
      run($urandom_range(0, 15), $urandom_range(0, 255), $urandom_range(0, 4), 1'($urandom_range(0, 1)), 8'($urandom));
    run(0, 0, 0, 0, 0);
    check("w16_sub_r", mem_wdata16, 16'hFFFF);
    check("w16_sub_c", carry16, 1);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
